// File: rtl/ap_txn_profiler.sv
// Per-transaction profiler for an ap_ctrl block: timestamps start, measures
// start-to-ready / start-to-done latency and counts loop iterations into a record FIFO.
module ap_txn_profiler #(
    parameter int CNT_W  = 32,
    parameter int ITER_W = 16,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_continue,
    input  logic              iter_end,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [CNT_W-1:0]  rec_start,
    output logic [CNT_W-1:0]  rec_rdy_lat,
    output logic [CNT_W-1:0]  rec_lat,
    output logic [ITER_W-1:0] rec_iters,
    output logic              rec_ovf,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = 3 * CNT_W + ITER_W + 1;
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0]  CYC_ONE  = CNT_W'(1);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cyc_r;
    logic [CNT_W-1:0]    start_r;
    logic [CNT_W-1:0]    rdy_lat_r;
    logic [CNT_W-1:0]    lat_r;
    logic [ITER_W-1:0]   iters_r;
    logic                ovf_r;
    logic                seen_r;
    logic                busy_r;
    logic [REC_W-1:0]    mem_r [DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [AW:0]         count_r;
    logic [DROP_W-1:0]   drop_r;

    logic [CNT_W-1:0]    start_base_s;
    logic [ITER_W-1:0]   iters_base_s;
    logic                ovf_base_s;
    logic                seen_base_s;
    logic [CNT_W-1:0]    elapsed_s;
    logic [ITER_W-1:0]   iters_nxt_s;
    logic                ovf_nxt_s;
    logic [CNT_W-1:0]    rdy_nxt_s;
    logic                seen_nxt_s;
    logic                push_s;
    logic [REC_W-1:0]    push_rec_s;
    logic                pop_s;
    logic                accept_s;
    logic                drop_s;

    // Transaction bookkeeping as seen this cycle; in IDLE the accumulators start from zero so the start cycle counts.
    always_comb begin
        if (state_r == ST_IDLE) begin
            start_base_s = cyc_r;
            iters_base_s = {ITER_W{1'b0}};
            ovf_base_s   = 1'b0;
            seen_base_s  = 1'b0;
        end else begin
            start_base_s = start_r;
            iters_base_s = iters_r;
            ovf_base_s   = ovf_r;
            seen_base_s  = seen_r;
        end
        elapsed_s = cyc_r - start_base_s;
        if (iter_end && (&iters_base_s)) begin
            iters_nxt_s = iters_base_s;
            ovf_nxt_s   = 1'b1;
        end else if (iter_end) begin
            iters_nxt_s = iters_base_s + ITER_ONE;
            ovf_nxt_s   = ovf_base_s;
        end else begin
            iters_nxt_s = iters_base_s;
            ovf_nxt_s   = ovf_base_s;
        end
        // Without an earlier ready, the ready latency falls back to the current elapsed time.
        rdy_nxt_s  = seen_base_s ? rdy_lat_r : elapsed_s;
        seen_nxt_s = seen_base_s | ap_ready;
        if (state_r == ST_DONE_WAIT) begin
            push_s     = ap_continue;
            push_rec_s = {start_r, rdy_lat_r, lat_r, iters_r, ovf_r};
        end else begin
            push_s     = ap_done && ap_continue && ((state_r == ST_BUSY) || ap_start);
            push_rec_s = {start_base_s, rdy_nxt_s, elapsed_s, iters_nxt_s, ovf_nxt_s};
        end
    end

    // FIFO handshake: a pop frees the slot a same-cycle push into a full FIFO needs.
    always_comb begin
        pop_s    = (count_r != CNT_ZERO) && rec_ready;
        accept_s = push_s && ((count_r != FULL_CNT) || pop_s);
        drop_s   = push_s && (count_r == FULL_CNT) && !pop_s;
    end

    // Free-running cycle counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_r <= {CNT_W{1'b0}};
        end else begin
            cyc_r <= cyc_r + CYC_ONE;
        end
    end

    // Transaction FSM with registered busy flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            start_r   <= {CNT_W{1'b0}};
            rdy_lat_r <= {CNT_W{1'b0}};
            lat_r     <= {CNT_W{1'b0}};
            iters_r   <= {ITER_W{1'b0}};
            ovf_r     <= 1'b0;
            seen_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ap_start) begin
                        start_r   <= cyc_r;
                        iters_r   <= iters_nxt_s;
                        ovf_r     <= ovf_nxt_s;
                        seen_r    <= seen_nxt_s;
                        rdy_lat_r <= rdy_nxt_s;
                        lat_r     <= elapsed_s;
                        if (ap_done && ap_continue) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else if (ap_done) begin
                            state_r <= ST_DONE_WAIT;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_BUSY;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    iters_r   <= iters_nxt_s;
                    ovf_r     <= ovf_nxt_s;
                    seen_r    <= seen_nxt_s;
                    rdy_lat_r <= rdy_nxt_s;
                    if (ap_done) begin
                        lat_r <= elapsed_s;
                        if (ap_continue) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DONE_WAIT;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DONE_WAIT: begin
                    if (ap_continue) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DONE_WAIT;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Record FIFO storage, pointers, occupancy and saturating drop counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {REC_W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            drop_r   <= {DROP_W{1'b0}};
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= push_rec_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s && !(&drop_r)) begin
                drop_r <= drop_r + DROP_ONE;
            end
        end
    end

    assign rec_valid = (count_r != CNT_ZERO);
    assign {rec_start, rec_rdy_lat, rec_lat, rec_iters, rec_ovf} = mem_r[rd_ptr_r];
    assign busy      = busy_r;
    assign drop_cnt  = drop_r;

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Scoreboard bench for ap_txn_profiler: a transaction-level model queues expected
// records, a negedge monitor compares them as the DUT presents and drains them.
module tb_ap_txn_profiler;

    localparam int CNT_W  = 8;
    localparam int ITER_W = 4;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1, iter_end = 1'b0;
    logic rec_ready = 1'b0;
    logic rec_valid, rec_ovf, busy;
    logic [CNT_W-1:0]  rec_start, rec_rdy_lat, rec_lat;
    logic [ITER_W-1:0] rec_iters;
    logic [DROP_W-1:0] drop_cnt;

    ap_txn_profiler #(.CNT_W(CNT_W), .ITER_W(ITER_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .iter_end(iter_end),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_start(rec_start),
        .rec_rdy_lat(rec_rdy_lat), .rec_lat(rec_lat), .rec_iters(rec_iters),
        .rec_ovf(rec_ovf), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int st;
        int rdy;
        int lat;
        int it;
        int ovf;
    } rec_t;

    rec_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Model state: time stamps are absolute cycle numbers of the profiler's own counter.
    int m_cyc = 0, t_start = 0, t_rdy = 0, t_done = 0, m_iters = 0, m_drops = 0;
    bit m_open = 0, m_done_seen = 0, m_have_rdy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % 256) + 256) % 256;
    endfunction

    // Reference model: applies the transaction rules to the inputs sampled at each edge.
    always @(posedge clock) begin
        if (!reset) begin
            m_cyc = 0; m_open = 0; m_done_seen = 0; m_drops = 0;
            exp_q.delete();
        end else begin
            if (!m_open && ap_start) begin
                m_open = 1; m_done_seen = 0; m_have_rdy = 0;
                t_start = m_cyc; m_iters = 0;
            end
            if (m_open && !m_done_seen) begin
                if (ap_ready && !m_have_rdy) begin
                    m_have_rdy = 1; t_rdy = m_cyc;
                end
                if (iter_end) m_iters++;
                if (ap_done) begin
                    m_done_seen = 1; t_done = m_cyc;
                end
            end
            if (m_open && m_done_seen && ap_continue) begin
                rec_t r;
                r.st  = t_start;
                r.lat = wrap(t_done - t_start);
                r.rdy = m_have_rdy ? wrap(t_rdy - t_start) : r.lat;
                r.it  = (m_iters > 15) ? 15 : m_iters;
                r.ovf = (m_iters > 15) ? 1 : 0;
                // The monitor already removed the entry being popped this edge.
                if (exp_q.size() < DEPTH) exp_q.push_back(r);
                else if (m_drops < 7) m_drops++;
                m_open = 0;
            end
            m_cyc = (m_cyc + 1) % 256;
        end
    end

    // Monitor: compares head record, valid, busy and drop count; pops on accepted handshake.
    always @(negedge clock) begin
        chk("rec_valid", {31'd0, rec_valid}, {31'd0, exp_q.size() != 0});
        chk("busy", {31'd0, busy}, {31'd0, m_open});
        chk("drop_cnt", {29'd0, drop_cnt}, m_drops);
        if (rec_valid && exp_q.size() != 0) begin
            chk("rec_start", {24'd0, rec_start}, exp_q[0].st);
            chk("rec_rdy_lat", {24'd0, rec_rdy_lat}, exp_q[0].rdy);
            chk("rec_lat", {24'd0, rec_lat}, exp_q[0].lat);
            chk("rec_iters", {28'd0, rec_iters}, exp_q[0].it);
            chk("rec_ovf", {31'd0, rec_ovf}, exp_q[0].ovf);
            if (rec_ready) void'(exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        rec_ready = 1'b1;
        repeat (DEPTH + 1) step();
        rec_ready = 1'b0;
    endtask

    // Generic transaction: start at offset 0, ready at rdy_off (<0: never), done at len,
    // iter_end on the first n_iter cycles, continue asserted cont_delay cycles after done.
    task automatic run_txn(input int len, input int rdy_off, input int n_iter, input int cont_delay);
        for (int c = 0; c <= len + cont_delay; c++) begin
            ap_start    = (c == 0);
            ap_ready    = (c == rdy_off);
            ap_done     = (c == len);
            iter_end    = (c < n_iter);
            ap_continue = (c >= len + cont_delay);
            step();
        end
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; iter_end = 1'b0; ap_continue = 1'b1;
    endtask

    initial begin
        step(); step();
        @(negedge clock);
        chk("rst_valid", {31'd0, rec_valid}, 32'd0);
        chk("rst_start", {24'd0, rec_start}, 32'd0);
        chk("rst_rdy_lat", {24'd0, rec_rdy_lat}, 32'd0);
        chk("rst_lat", {24'd0, rec_lat}, 32'd0);
        chk("rst_iters", {28'd0, rec_iters}, 32'd0);
        chk("rst_ovf", {31'd0, rec_ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drop", {29'd0, drop_cnt}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Start at cyc 10 with ready, 8 iterations, done+continue at cyc 25.
        repeat (10) step();
        ap_start = 1'b1; ap_ready = 1'b1; iter_end = 1'b1;
        step();
        ap_start = 1'b0; ap_ready = 1'b0;
        repeat (7) step();
        iter_end = 1'b0;
        repeat (7) step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        @(negedge clock);
        chk("t1_valid", {31'd0, rec_valid}, 32'd1);
        chk("t1_start", {24'd0, rec_start}, 32'd10);
        chk("t1_rdy", {24'd0, rec_rdy_lat}, 32'd0);
        chk("t1_lat", {24'd0, rec_lat}, 32'd15);
        chk("t1_iters", {28'd0, rec_iters}, 32'd8);
        drain();

        // Done held off by continue; iteration after done is ignored.
        ap_continue = 1'b0; ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        repeat (3) step();
        ap_done = 1'b1;
        step();
        ap_done = 1'b0;
        step();
        iter_end = 1'b1;
        step();
        iter_end = 1'b0;
        step();
        ap_continue = 1'b1;
        step();
        @(negedge clock);
        chk("t2_lat", {24'd0, rec_lat}, 32'd4);
        chk("t2_rdy", {24'd0, rec_rdy_lat}, 32'd4);
        chk("t2_iters", {28'd0, rec_iters}, 32'd0);
        drain();

        // Five records into a depth-4 FIFO with no consumer.
        for (int i = 0; i < 5; i++) run_txn(3 + i, 1, i, 0);
        @(negedge clock);
        chk("t3_drop", {29'd0, drop_cnt}, 32'd1);
        drain();
        @(negedge clock);
        chk("t3_empty", {31'd0, rec_valid}, 32'd0);

        // Iteration counter saturation.
        run_txn(22, 2, 20, 0);
        @(negedge clock);
        chk("t4_iters", {28'd0, rec_iters}, 32'd15);
        chk("t4_ovf", {31'd0, rec_ovf}, 32'd1);
        drain();

        // Latency across counter wrap, then start and done in the same cycle.
        for (int g = 0; g < 300 && m_cyc != 253; g++) step();
        run_txn(6, 3, 2, 0);
        @(negedge clock);
        chk("t5_start", {24'd0, rec_start}, 32'd253);
        chk("t5_lat", {24'd0, rec_lat}, 32'd6);
        drain();
        run_txn(0, 0, 1, 0);
        @(negedge clock);
        chk("t5_same_busy", {31'd0, busy}, 32'd0);
        chk("t5_same_lat", {24'd0, rec_lat}, 32'd0);
        drain();

        // Reset while busy with a record queued.
        run_txn(2, -1, 0, 0);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clock);
        chk("t6_valid", {31'd0, rec_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_drop", {29'd0, drop_cnt}, 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            ap_start    = ($urandom_range(2) == 0);
            ap_ready    = ($urandom_range(3) == 0);
            ap_done     = ($urandom_range(3) == 0);
            ap_continue = ($urandom_range(3) != 0);
            iter_end    = ($urandom_range(1) == 0);
            rec_ready   = ($urandom_range(2) == 0);
            step();
        end

        // Close any open transaction and drain everything.
        ap_start = 1'b0; ap_ready = 1'b0; iter_end = 1'b0;
        ap_done = 1'b1; ap_continue = 1'b1; rec_ready = 1'b1;
        repeat (2) step();
        ap_done = 1'b0;
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) step();
        @(negedge clock);
        chk("final_drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
